// File: rtl/nco_tuning_word_meter.sv
// Gated edge counter that converts a square-wave frequency back into an NCO phase increment.
// Optional NCO_METER_DEGLITCH_EN inserts a 3-tap majority filter ahead of the edge detector.
module nco_tuning_word_meter #(
    parameter int unsigned REGISTER_WIDTH = 64,
    parameter int unsigned GATE_LOG2      = 20,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      sig_in,
    input  logic                      enable,
    output logic [REGISTER_WIDTH-1:0] phase_increment_out,
    output logic [GATE_LOG2-1:0]      edge_count,
    output logic                      no_signal,
    output logic                      result_valid,
    output logic                      busy
);

    localparam int unsigned RESULT_SHIFT = REGISTER_WIDTH - GATE_LOG2;
    localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic                   det_in;
    logic                   det_d;
    logic                   rise;
    logic [GATE_LOG2-1:0]   gate_cnt;
    logic [GATE_LOG2-1:0]   edge_cnt;
    logic [GATE_LOG2-1:0]   total;

    // Metastability synchroniser for the asynchronous input
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

`ifdef NCO_METER_DEGLITCH_EN
    logic [1:0] tap;
    logic       filt;

    // Majority vote over three consecutive samples drops single-cycle pulses and gaps
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tap  <= '0;
            filt <= 1'b0;
        end else begin
            tap  <= {tap[0], sync_q};
            filt <= (sync_q & tap[0]) | (sync_q & tap[1]) | (tap[0] & tap[1]);
        end
    end

    assign det_in = filt;
`else
    assign det_in = sync_q;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            det_d <= 1'b0;
        end else begin
            det_d <= det_in;
        end
    end

    assign rise  = det_in & ~det_d;
    assign total = edge_cnt + GATE_LOG2'(rise);

    // Window control, counting and result registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state               <= IDLE;
            gate_cnt            <= '0;
            edge_cnt            <= '0;
            phase_increment_out <= '0;
            edge_count          <= '0;
            no_signal           <= 1'b0;
            result_valid        <= 1'b0;
            busy                <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    if (enable) begin
                        state <= MEASURE;
                        busy  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (gate_cnt == GATE_LAST) begin
                        // The closing window publishes its result even if enable just dropped
                        edge_count          <= total;
                        phase_increment_out <= REGISTER_WIDTH'(total) << RESULT_SHIFT;
                        no_signal           <= (total == '0);
                        result_valid        <= 1'b1;
                        gate_cnt            <= '0;
                        edge_cnt            <= '0;
                        if (!enable) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!enable) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_LOG2'(1);
                        edge_cnt <= total;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_tuning_word_meter.sv
// Scoreboard bench for nco_tuning_word_meter at REGISTER_WIDTH=16, GATE_LOG2=8.
module tb_nco_tuning_word_meter;

    localparam int unsigned RW = 16;
    localparam int unsigned GL = 8;

    localparam int MODE_LOW    = 0;
    localparam int MODE_SQUARE = 1;
    localparam int MODE_PULSE  = 2;
    localparam int MODE_NCO    = 3;

`ifdef NCO_METER_DEGLITCH_EN
    localparam int PULSE_EDGES = 0;
`else
    localparam int PULSE_EDGES = 16;
`endif

    typedef struct {
        bit chk;
        int ec_lo;
        int ec_hi;
        int ns;
    } exp_t;

    logic          clk = 1'b0;
    logic          arst;
    logic          sig_in;
    logic          enable;
    logic [RW-1:0] phase_increment_out;
    logic [GL-1:0] edge_count;
    logic          no_signal;
    logic          result_valid;
    logic          busy;

    exp_t      sb[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        n_valid = 0;
    int        mode    = MODE_LOW;
    int        gen_cnt = 0;
    logic [15:0] nco_acc = '0;
    logic [15:0] nco_inc = '0;

    nco_tuning_word_meter #(
        .REGISTER_WIDTH(RW),
        .GATE_LOG2     (GL),
        .SYNC_STAGES   (2)
    ) dut (
        .clk                (clk),
        .arst               (arst),
        .sig_in             (sig_in),
        .enable             (enable),
        .phase_increment_out(phase_increment_out),
        .edge_count         (edge_count),
        .no_signal          (no_signal),
        .result_valid       (result_valid),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d..%0d", name, act, act, lo, hi);
        end
    endtask

    // Expected window result; phase expectation follows as edges << (RW-GL)
    task automatic push(input bit chk, input int ec_lo, input int ec_hi, input int ns);
        exp_t e;
        e.chk   = chk;
        e.ec_lo = ec_lo;
        e.ec_hi = ec_hi;
        e.ns    = ns;
        sb.push_back(e);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!result_valid && cyc < 1000);
        if (!result_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid: no result_valid within %0d cycles", cyc);
        end
    endtask

    // Input waveform generator, updated 2 ns after each rising edge
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            gen_cnt++;
            case (mode)
                MODE_SQUARE: sig_in = (gen_cnt % 16) < 8;
                MODE_PULSE:  sig_in = (gen_cnt % 16) == 0;
                MODE_NCO: begin
                    nco_acc = nco_acc + nco_inc;
                    sig_in  = nco_acc[15];
                end
                default:     sig_in = 1'b0;
            endcase
        end
    end

    // Monitor: pop and compare on every result pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                n_valid++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: edge_count=%0d with empty scoreboard", edge_count);
                end else begin
                    e = sb.pop_front();
                    if (e.chk) begin
                        check("sb_edge_count", int'(edge_count), e.ec_lo, e.ec_hi);
                        check("sb_phase_increment", int'(phase_increment_out),
                              e.ec_lo << (RW - GL), e.ec_hi << (RW - GL));
                        check("sb_no_signal", int'(no_signal), e.ns, e.ns);
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        int nv;
        arst   = 1'b1;
        enable = 1'b0;

        #3;
        check("rst_phase", int'(phase_increment_out), 0, 0);
        check("rst_edge_count", int'(edge_count), 0, 0);
        check("rst_no_signal", int'(no_signal), 0, 0);
        check("rst_valid", int'(result_valid), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        repeat (3) @(posedge clk);
        #3 arst = 1'b0;

        // Square wave, period 16, back-to-back windows
        mode = MODE_SQUARE;
        repeat (20) @(posedge clk);
        #1;
        push(0, 0, 0, 0);
        repeat (3) push(1, 16, 16, 0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(cyc);
            if (i == 0) check("first_window_latency", cyc, 257, 257);
            else        check("window_period", cyc, 256, 256);
        end

        // Asynchronous reset mid-window
        repeat (50) @(posedge clk);
        #3 arst = 1'b1;
        #1;
        check("arst_phase", int'(phase_increment_out), 0, 0);
        check("arst_edge_count", int'(edge_count), 0, 0);
        check("arst_no_signal", int'(no_signal), 0, 0);
        check("arst_valid", int'(result_valid), 0, 0);
        check("arst_busy", int'(busy), 0, 0);
        repeat (3) @(posedge clk);
        #3 arst = 1'b0;
        push(0, 0, 0, 0);
        wait_valid(cyc);
        check("arst_restart_latency", cyc, 257, 257);

        // Enable dropped at window cycle 100 after a 0x1000 result
        push(1, 16, 16, 0);
        wait_valid(cyc);
        check("window_period_after_arst", cyc, 256, 256);
        repeat (100) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0, 0);
        nv = n_valid;
        repeat (300) @(posedge clk);
        #1;
        check("abort_no_valid", n_valid - nv, 0, 0);
        check("abort_hold_phase", int'(phase_increment_out), 16'h1000, 16'h1000);
        check("abort_hold_edge_count", int'(edge_count), 16, 16);
        push(1, 16, 16, 0);
        enable = 1'b1;
        wait_valid(cyc);
        check("reenable_latency", cyc, 257, 257);

        // No input activity for a full window
        mode = MODE_LOW;
        push(0, 0, 0, 0);
        push(1, 0, 0, 1);
        repeat (2) wait_valid(cyc);

        // NCO loopback: phase_increment / 2^16 * 256 edges per window, +-1 edge
        nco_inc = 16'h0A00;
        mode    = MODE_NCO;
        push(0, 0, 0, 0);
        repeat (2) push(1, 9, 11, 0);
        repeat (3) wait_valid(cyc);
        nco_inc = 16'h2800;
        push(0, 0, 0, 0);
        repeat (2) push(1, 39, 41, 0);
        repeat (3) wait_valid(cyc);

        // Single-cycle pulses every 16 cycles
        mode = MODE_PULSE;
        push(0, 0, 0, 0);
        repeat (2) push(1, PULSE_EDGES, PULSE_EDGES, (PULSE_EDGES == 0) ? 1 : 0);
        repeat (3) wait_valid(cyc);

        #1 enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
